// File: rtl/ctrl_fsm.sv
// Multi-cycle MIPS-subset controller: a Moore FSM that steps each instruction
// through FETCH/DCD/EXE/MEM/WB. It drives the datapath write enables and mux
// selects, and it counts retired instructions.
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [1:0]  npcop,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic [3:0]  aluop,
  output logic        sel,
  output logic [1:0]  D_sel,
  output logic [1:0]  R_sel,
  output logic [1:0]  extop,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StFetch = 3'b000,
    StDcd   = 3'b001,
    StExe   = 3'b010,
    StMem   = 3'b011,
    StWb    = 3'b100
  } state_e;

  typedef enum logic [3:0] {
    InAddu, InSubu, InAnd, InOr, InSlt, InJr,
    InOri, InAddiu, InLui, InLw, InSw, InBeq, InJ, InJal, InIll
  } instr_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluOr   = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluSlt  = 4'b0100;

  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtLui  = 2'b10;

  localparam logic [1:0] NpcSeq  = 2'b00;
  localparam logic [1:0] NpcBr   = 2'b01;
  localparam logic [1:0] NpcJ    = 2'b10;
  localparam logic [1:0] NpcJr   = 2'b11;

  localparam logic [1:0] DselAlu = 2'b00;
  localparam logic [1:0] DselDl  = 2'b01;
  localparam logic [1:0] DselNpc = 2'b10;

  localparam logic [1:0] RselRt  = 2'b00;
  localparam logic [1:0] RselRd  = 2'b01;
  localparam logic [1:0] Rsel31  = 2'b10;

  state_e      state_q, state_d;
  instr_e      instr;
  logic [3:0]  alu_op_c;
  logic        alu_sel_c;
  logic [1:0]  alu_ext_c;
  logic [31:0] retired_q;

  // Classify the current op/funct. Anything unrecognised, including X, is illegal.
  always_comb begin
    instr = InIll;
    case (op)
      OpRtype: begin
        case (funct)
          FnAddu:  instr = InAddu;
          FnSubu:  instr = InSubu;
          FnAnd:   instr = InAnd;
          FnOr:    instr = InOr;
          FnSlt:   instr = InSlt;
          FnJr:    instr = InJr;
          default: instr = InIll;
        endcase
      end
      OpOri:   instr = InOri;
      OpAddiu: instr = InAddiu;
      OpLui:   instr = InLui;
      OpLw:    instr = InLw;
      OpSw:    instr = InSw;
      OpBeq:   instr = InBeq;
      OpJ:     instr = InJ;
      OpJal:   instr = InJal;
      default: instr = InIll;
    endcase
  end

  // ALU controls for each instruction. They are set up in EXE and held through MEM/WB.
  always_comb begin
    alu_op_c  = AluAdd;
    alu_sel_c = 1'b0;
    alu_ext_c = ExtZero;
    case (instr)
      InSubu:  alu_op_c = AluSub;
      InAnd:   alu_op_c = AluAnd;
      InOr:    alu_op_c = AluOr;
      InSlt:   alu_op_c = AluSlt;
      InOri: begin
        alu_op_c  = AluOr;
        alu_sel_c = 1'b1;
        alu_ext_c = ExtZero;
      end
      InAddiu, InLw, InSw: begin
        alu_op_c  = AluAdd;
        alu_sel_c = 1'b1;
        alu_ext_c = ExtSign;
      end
      InLui: begin
        alu_op_c  = AluAdd;
        alu_sel_c = 1'b1;
        alu_ext_c = ExtLui;
      end
      InBeq: begin
        alu_op_c  = AluSub;
        alu_sel_c = 1'b0;
        alu_ext_c = ExtSign;
      end
      default: ;
    endcase
  end

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDcd;
      StDcd: begin
        case (instr)
          InJ, InJal, InJr, InIll: state_d = StFetch;
          default:                 state_d = StExe;
        endcase
      end
      StExe: begin
        case (instr)
          InAddu, InSubu, InAnd, InOr, InSlt,
          InOri, InAddiu, InLui:              state_d = StWb;
          InLw, InSw:                         state_d = StMem;
          default:                            state_d = StFetch;
        endcase
      end
      StMem: begin
        case (instr)
          InLw:    state_d = StWb;
          default: state_d = StFetch;
        endcase
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Moore outputs. While reset is low, the enables and the illegal flag are forced low.
  always_comb begin
    npcop   = NpcSeq;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    aluop   = AluAdd;
    sel     = 1'b0;
    D_sel   = DselAlu;
    R_sel   = RselRt;
    extop   = ExtZero;
    illegal = 1'b0;
    case (state_q)
      StFetch: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      StDcd: begin
        case (instr)
          InJ: begin
            PCWr  = 1'b1;
            npcop = NpcJ;
          end
          InJal: begin
            PCWr  = 1'b1;
            npcop = NpcJ;
            RFWr  = 1'b1;
            R_sel = Rsel31;
            D_sel = DselNpc;
          end
          InJr: begin
            PCWr  = 1'b1;
            npcop = NpcJr;
          end
          InIll:   illegal = 1'b1;
          default: ;
        endcase
      end
      StExe: begin
        case (instr)
          InAddu, InSubu, InAnd, InOr, InSlt,
          InOri, InAddiu, InLui, InLw, InSw: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
          end
          InBeq: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
            npcop = NpcBr;
            PCWr  = zero;
          end
          default: ;
        endcase
      end
      StMem: begin
        case (instr)
          InLw: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
          end
          InSw: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
            DMWr  = 1'b1;
          end
          default: ;
        endcase
      end
      StWb: begin
        case (instr)
          InLw: begin
            RFWr  = 1'b1;
            D_sel = DselDl;
            R_sel = RselRt;
          end
          InAddu, InSubu, InAnd, InOr, InSlt: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
            RFWr  = 1'b1;
            D_sel = DselAlu;
            R_sel = RselRd;
          end
          InOri, InAddiu, InLui: begin
            aluop = alu_op_c;
            sel   = alu_sel_c;
            extop = alu_ext_c;
            RFWr  = 1'b1;
            D_sel = DselAlu;
            R_sel = RselRt;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (!rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      DMWr    = 1'b0;
      illegal = 1'b0;
    end
  end

  // Retired counter: one count per return to FETCH from any other state. Wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= 32'd0;
    end else if (state_q != StFetch && state_d == StFetch) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: checks the per-cycle output vectors of each instruction class,
// the retired count, and asynchronous reset.
module tb_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic [1:0]  npcop;
  logic        PCWr, IRWr, RFWr, DMWr;
  logic [3:0]  aluop;
  logic        sel;
  logic [1:0]  D_sel, R_sel, extop;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret = 32'd0;

  // {state, PCWr, IRWr, RFWr, DMWr, illegal, npcop, aluop, sel, D_sel, R_sel, extop}
  logic [20:0] obs;
  assign obs = {state, PCWr, IRWr, RFWr, DMWr, illegal, npcop, aluop, sel, D_sel, R_sel, extop};

  localparam logic [20:0] VFetch = {3'd0, 5'b11000, 13'd0};
  localparam logic [20:0] VDcd   = {3'd1, 18'd0};
  localparam logic [20:0] VZero  = 21'd0;

  ctrl_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .npcop   (npcop),
    .PCWr    (PCWr),
    .IRWr    (IRWr),
    .RFWr    (RFWr),
    .DMWr    (DMWr),
    .aluop   (aluop),
    .sel     (sel),
    .D_sel   (D_sel),
    .R_sel   (R_sel),
    .extop   (extop),
    .state   (state),
    .illegal (illegal),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic [2:0] st, input logic [4:0] en,
                                     input logic [1:0] npc, input logic [3:0] alu,
                                     input logic s, input logic [1:0] ds,
                                     input logic [1:0] rs, input logic [1:0] ex);
    return {st, en, npc, alu, s, ds, rs, ex};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
    #3;
    checks++;
    if (obs !== VZero || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: got obs=%h ret=%0d exp obs=%h ret=0", obs, retired, VZero);
    end
    tick();
    checks++;
    if (obs !== VZero || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_clocked: got obs=%h ret=%0d exp obs=%h ret=0", obs, retired, VZero);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== VFetch) begin
      failures++;
      $display("FAIL reset_release: got %h exp %h", obs, VFetch);
    end
  endtask

  task automatic test_addu();
    logic [20:0] e [$];
    op = 6'b000000; funct = 6'b100001;
    e = '{VFetch, VDcd, pk(3'd2, 5'b00000, 2'b00, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00),
          pk(3'd4, 5'b00100, 2'b00, 4'd0, 1'b0, 2'b00, 2'b01, 2'b00)};
    foreach (e[i]) begin
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL addu_cyc%0d: got %h exp %h", i, obs, e[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL addu_retire: got st=%0d ret=%0d exp st=0 ret=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [4] = '{6'b100011, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] al [4] = '{4'd1, 4'd3, 4'd2, 4'd4};
    logic [20:0] e [$];
    for (int k = 0; k < 4; k++) begin
      op = 6'b000000; funct = fn[k];
      e = '{VFetch, VDcd, pk(3'd2, 5'b00000, 2'b00, al[k], 1'b0, 2'b00, 2'b00, 2'b00),
            pk(3'd4, 5'b00100, 2'b00, al[k], 1'b0, 2'b00, 2'b01, 2'b00)};
      foreach (e[i]) begin
        checks++;
        if (obs !== e[i]) begin
          failures++;
          $display("FAIL rtype_f%0h_cyc%0d: got %h exp %h", fn[k], i, obs, e[i]);
        end
        tick();
      end
      exp_ret++;
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL rtype_retire: got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_itype();
    logic [5:0] opc [3] = '{6'b001101, 6'b001001, 6'b001111};
    logic [3:0] al  [3] = '{4'd2, 4'd0, 4'd0};
    logic [1:0] ex  [3] = '{2'b00, 2'b01, 2'b10};
    logic [20:0] e [$];
    for (int k = 0; k < 3; k++) begin
      op = opc[k]; funct = 6'b111111;
      e = '{VFetch, VDcd, pk(3'd2, 5'b00000, 2'b00, al[k], 1'b1, 2'b00, 2'b00, ex[k]),
            pk(3'd4, 5'b00100, 2'b00, al[k], 1'b1, 2'b00, 2'b00, ex[k])};
      foreach (e[i]) begin
        checks++;
        if (obs !== e[i]) begin
          failures++;
          $display("FAIL itype_op%0h_cyc%0d: got %h exp %h", opc[k], i, obs, e[i]);
        end
        tick();
      end
      exp_ret++;
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL itype_retire: got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_lw_sw();
    logic [20:0] e [$];
    logic [31:0] start_ret = exp_ret;
    op = 6'b100011; funct = 6'd0;
    e = '{VFetch, VDcd, pk(3'd2, 5'b00000, 2'b00, 4'd0, 1'b1, 2'b00, 2'b00, 2'b01),
          pk(3'd3, 5'b00000, 2'b00, 4'd0, 1'b1, 2'b00, 2'b00, 2'b01),
          pk(3'd4, 5'b00100, 2'b00, 4'd0, 1'b0, 2'b01, 2'b00, 2'b00)};
    foreach (e[i]) begin
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL lw_cyc%0d: got %h exp %h", i, obs, e[i]);
      end
      tick();
    end
    op = 6'b101011;
    e = '{VFetch, VDcd, pk(3'd2, 5'b00000, 2'b00, 4'd0, 1'b1, 2'b00, 2'b00, 2'b01),
          pk(3'd3, 5'b00010, 2'b00, 4'd0, 1'b1, 2'b00, 2'b00, 2'b01)};
    foreach (e[i]) begin
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL sw_cyc%0d: got %h exp %h", i, obs, e[i]);
      end
      tick();
    end
    exp_ret = start_ret + 32'd2;
    checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL lw_sw_retire: got st=%0d ret=%0d exp st=0 ret=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_beq();
    logic [20:0] e [$];
    for (int z = 1; z >= 0; z--) begin
      op = 6'b000100; funct = 6'd0; zero = (z == 1);
      e = '{VFetch, VDcd,
            pk(3'd2, {zero, 4'b0000}, 2'b01, 4'd1, 1'b0, 2'b00, 2'b00, 2'b01), VFetch};
      foreach (e[i]) begin
        checks++;
        if (obs !== e[i]) begin
          failures++;
          $display("FAIL beq_z%0d_cyc%0d: got %h exp %h", z, i, obs, e[i]);
        end
        if (i < 3) tick();
      end
      exp_ret++;
    end
    zero = 1'b0;
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL beq_retire: got %0d exp %0d", retired, exp_ret);
    end
  endtask

  task automatic test_jumps();
    logic [5:0]  opc [3] = '{6'b000010, 6'b000011, 6'b000000};
    logic [20:0] dv  [3];
    dv[0] = pk(3'd1, 5'b10000, 2'b10, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    dv[1] = pk(3'd1, 5'b10100, 2'b10, 4'd0, 1'b0, 2'b10, 2'b10, 2'b00);
    dv[2] = pk(3'd1, 5'b10000, 2'b11, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      op = opc[k]; funct = 6'b001000;
      checks++;
      if (obs !== VFetch) begin
        failures++;
        $display("FAIL jump%0d_fetch: got %h exp %h", k, obs, VFetch);
      end
      tick();
      checks++;
      if (obs !== dv[k]) begin
        failures++;
        $display("FAIL jump%0d_dcd: got %h exp %h", k, obs, dv[k]);
      end
      tick();
      exp_ret++;
      checks++;
      if (state !== 3'd0 || retired !== exp_ret) begin
        failures++;
        $display("FAIL jump%0d_retire: got st=%0d ret=%0d exp st=0 ret=%0d",
                 k, state, retired, exp_ret);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] opc [2] = '{6'b111111, 6'b000000};
    logic [5:0] fnc [2] = '{6'b100001, 6'b000000};
    logic [20:0] vill;
    vill = pk(3'd1, 5'b00001, 2'b00, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 2; k++) begin
      op = opc[k]; funct = fnc[k];
      checks++;
      if (obs !== VFetch) begin
        failures++;
        $display("FAIL illegal%0d_fetch: got %h exp %h", k, obs, VFetch);
      end
      tick();
      checks++;
      if (obs !== vill) begin
        failures++;
        $display("FAIL illegal%0d_dcd: got %h exp %h", k, obs, vill);
      end
      tick();
      exp_ret++;
      checks++;
      if (obs !== VFetch || retired !== exp_ret) begin
        failures++;
        $display("FAIL illegal%0d_retire: got obs=%h ret=%0d exp obs=%h ret=%0d",
                 k, obs, retired, VFetch, exp_ret);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [20:0] vmem;
    vmem = pk(3'd3, 5'b00010, 2'b00, 4'd0, 1'b1, 2'b00, 2'b00, 2'b01);
    op = 6'b101011; funct = 6'd0;
    tick();
    tick();
    tick();
    checks++;
    if (obs !== vmem) begin
      failures++;
      $display("FAIL async_pre_mem: got %h exp %h", obs, vmem);
    end
    #2;
    rst = 1'b0;
    #1;
    exp_ret = 32'd0;
    checks++;
    if (obs !== VZero || retired !== exp_ret) begin
      failures++;
      $display("FAIL async_reset: got obs=%h ret=%0d exp obs=%h ret=0", obs, retired, VZero);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== VFetch) begin
      failures++;
      $display("FAIL async_refetch: got %h exp %h", obs, VFetch);
    end
    tick();
    checks++;
    if (obs !== VDcd || retired !== 32'd0) begin
      failures++;
      $display("FAIL async_dcd: got obs=%h ret=%0d exp obs=%h ret=0", obs, retired, VDcd);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_rtype();
    test_itype();
    test_lw_sw();
    test_beq();
    test_jumps();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low (0 = reset).
REQ-003 SHALL have port op, input, 6, IR[31:26] from datapath.
REQ-004 SHALL have port funct, input, 6, IR[5:0] from datapath.
REQ-005 SHALL have port zero, input, 1, ALU equality flag.
REQ-006 SHALL have port npcop, output, 2, next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
REQ-007 SHALL have outputs PCWr, IRWr, RFWr and DMWr, each 1 bit, each a write enable.
REQ-008 SHALL have port aluop, output, 4, ALU function: 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 SLT.
REQ-009 SHALL have port sel, output, 1, ALU B operand: 0 register B, 1 Imm32.
REQ-010 SHALL have port D_sel, output, 2, RF write data: 00 ALU result, 01 DL output, 10 npc.
REQ-011 SHALL have port R_sel, output, 2, RF write address: 00 rt, 01 rd, 10 $31.
REQ-012 SHALL have port extop, output, 2, immediate extension: 00 zero-extend, 01 sign-extend, 10 lui (imm<<16).
REQ-013 SHALL have port state, output, 3, current state: FETCH 000, DCD 001, EXE 010, MEM 011, WB 100.
REQ-014 SHALL have port illegal, output, 1, high in DCD when the opcode is unsupported.
REQ-015 SHALL have port retired, output, 32, count of completed instructions.

Function
REQ-016 SHALL decode addu(op 0, funct 100001), subu(100011), and(100100), or(100101), slt(101010) and jr(001000).
REQ-017 SHALL also decode ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010 and jal 000011; every other op/funct combination is illegal.
REQ-018 SHALL implement a Moore FSM in which outputs depend only on state, op and funct; no output is registered.
REQ-019 SHALL hold all enables at 0, npcop=00 and all other selects at 00/0 in any state/instruction not listed below.
REQ-020 SHALL, in FETCH, drive IRWr=1, PCWr=1 and npcop=00, then go to DCD unconditionally.
REQ-021 SHALL, in DCD for j, drive PCWr=1 and npcop=10, then go to FETCH.
REQ-022 SHALL, in DCD for jal, drive PCWr=1, npcop=10, RFWr=1, R_sel=10 and D_sel=10, then go to FETCH.
REQ-023 SHALL, in DCD for jr, drive PCWr=1 and npcop=11, then go to FETCH.
REQ-024 SHALL, in DCD for an illegal instruction, drive illegal=1 with no write enables, then go to FETCH (executed as a NOP).
REQ-025 SHALL, in DCD for all other instructions, assert no enables and go to EXE.
REQ-026 SHALL, in EXE for R-type, drive sel=0 and aluop per funct (addu ADD, subu SUB, and AND, or OR, slt SLT), then go to WB.
REQ-027 SHALL, in EXE for ori, drive sel=1, extop=00 and aluop=OR; for addiu, sel=1, extop=01 and ADD; for lui, sel=1, extop=10 and ADD; then go to WB.
REQ-028 SHALL, in EXE for lw/sw, drive sel=1, extop=01 and aluop=ADD, then go to MEM.
REQ-029 SHALL, in EXE for beq, drive sel=0, aluop=SUB, extop=01, npcop=01 and PCWr=zero, then go to FETCH.
REQ-030 SHALL, in MEM for sw, hold the EXE ALU controls and drive DMWr=1, then go to FETCH.
REQ-031 SHALL, in MEM for lw, hold the EXE ALU controls with DMWr=0, then go to WB.
REQ-032 SHALL, in WB for lw, drive RFWr=1, D_sel=01 and R_sel=00.
REQ-033 SHALL, in WB for R-type, drive RFWr=1, D_sel=00 and R_sel=01, holding the EXE ALU controls.
REQ-034 SHALL, in WB for ori/addiu/lui, drive RFWr=1, D_sel=00 and R_sel=00, holding the EXE ALU controls.
REQ-035 SHALL go from WB to FETCH.
REQ-036 SHALL increment retired by 1 on every transition from a non-FETCH state into FETCH, including illegal NOPs, wrapping 0xFFFFFFFF to 0.
REQ-037 SHALL give instruction latencies of j/jal/jr/illegal 2, beq 3, sw 4, R/I-ALU 4 and lw 5 cycles.
REQ-038 SHALL, when op/funct are X or unsupported in EXE/MEM/WB, fall back to FETCH with no enables asserted.

Reset
REQ-039 SHALL, while rst=0, immediately force state=FETCH and retired=0 and hold PCWr, IRWr, RFWr, DMWr and illegal at 0, independent of clk.
REQ-040 SHALL, on reset assertion mid-instruction, abort the instruction with no further writes.
REQ-041 SHALL, on the first rising clk edge after rst rises, perform a FETCH cycle.

Verification
REQ-042 SHALL cover: reset, then addu (op 0, funct 100001) -> state 000,001,010,100,000; RFWr=1, R_sel=01, D_sel=00 only in WB; retired=1.
REQ-043 SHALL cover: lw then sw -> lw 5 cycles with D_sel=01 in WB; sw DMWr=1 in MEM only; retired=2 after 9 cycles.
REQ-044 SHALL cover: beq with zero=1 and then zero=0 -> PCWr=1, npcop=01 in EXE for zero=1 only; 3 cycles each.
REQ-045 SHALL cover: jal -> in DCD PCWr=1, RFWr=1, R_sel=10, D_sel=10, npcop=10; next state FETCH.
REQ-046 SHALL cover: op 111111 -> illegal=1 in DCD only, no enables, retired increments.
REQ-047 SHALL cover: rst=0 asynchronously in MEM of sw -> DMWr drops at once, state=000 and retired=0 with no clk edge.
